// File: rtl/pipe_pkg.sv
// Shared definitions for the memory-to-write-back pipeline slice.
//   DATA_W_DEF / ADDR_W_DEF : default data and register-address widths
//   WB_SEL_*                : write-back mux select encodings
//   wb_bundle_t             : default-width memory-stage result bundle
//   bundle_width()          : packed bundle width for arbitrary widths
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_DM  = 1'b1;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] dm_data;
    logic [DATA_W_DEF-1:0] alu_data;
    logic [ADDR_W_DEF-1:0] rd_addr;
    logic                  w_enable;
    logic                  wb_sel;
  } wb_bundle_t;

  function automatic int unsigned bundle_width(int unsigned dw, int unsigned aw);
    return 2 * dw + aw + 2;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One bundle register with an occupancy bit.
//   clk, rst_n : clock, synchronous active-low reset (clears data and valid)
//   load       : capture d and mark the slot occupied
//   clear      : mark the slot empty (data left stale); wins over load
//   d / q      : bundle in / held bundle
//   valid      : slot occupied
module pipe_skid_slot #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// Memory-stage to write-back pipeline register with valid/ready handshake.
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : drop everything held and anything accepted this cycle
//   in_valid / in_ready : upstream handshake; in_* carry the memory-stage bundle
//   out_valid/out_ready : downstream handshake; out_* carry the registered bundle
//   out_wb_data         : selected write-back value (dm data or ALU result)
//   fwd_*               : write-back forwarding port for earlier stages
// SKID=1 adds a second slot so in_ready comes straight from a flop.
module mem_wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dm_data,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic              in_w_enable,
  input  logic              in_wb_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_dm_data,
  output logic [DATA_W-1:0] out_alu_data,
  output logic [ADDR_W-1:0] out_rd_addr,
  output logic              out_w_enable,
  output logic              out_wb_sel,
  output logic [DATA_W-1:0] out_wb_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd_addr,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int unsigned BW = bundle_width(DATA_W, ADDR_W);

  typedef struct packed {
    logic [DATA_W-1:0] dm_data;
    logic [DATA_W-1:0] alu_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              w_enable;
    logic              wb_sel;
  } bundle_t;

  bundle_t in_b, main_d, main_q;
  logic    main_valid, main_load, main_clear;
  logic    accept, handoff;

  // x0 is hardwired zero: squash the write request before it is stored.
  assign in_b = '{
    dm_data:  in_dm_data,
    alu_data: in_alu_data,
    rd_addr:  in_rd_addr,
    w_enable: in_w_enable & (in_rd_addr != '0),
    wb_sel:   in_wb_sel
  };

  assign accept  = in_valid & in_ready;
  assign handoff = main_valid & out_ready;

  pipe_skid_slot #(.W(BW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  if (SKID != 0) begin : g_skid
    bundle_t skid_q;
    logic    skid_valid, skid_load, skid_clear;

    // in_ready never rises while the skid is full, so an accept and a
    // skid-to-main move cannot coincide.
    assign in_ready   = ~skid_valid;
    assign skid_load  = accept & main_valid & ~out_ready & ~flush;
    assign skid_clear = flush | handoff;
    assign main_load  = ~flush & ((handoff & skid_valid) |
                                  (accept & (~main_valid | out_ready)));
    assign main_d     = skid_valid ? skid_q : in_b;
    assign main_clear = flush | (handoff & ~main_load);

    pipe_skid_slot #(.W(BW)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_b),
      .valid (skid_valid),
      .q     (skid_q)
    );
  end else begin : g_single
    assign in_ready   = out_ready | ~main_valid;
    assign main_load  = accept & ~flush;
    assign main_d     = in_b;
    assign main_clear = flush | (handoff & ~main_load);
  end

  assign out_valid    = main_valid;
  assign out_dm_data  = main_q.dm_data;
  assign out_alu_data = main_q.alu_data;
  assign out_rd_addr  = main_q.rd_addr;
  assign out_w_enable = main_q.w_enable & main_valid;
  assign out_wb_sel   = main_q.wb_sel;
  assign out_wb_data  = (main_q.wb_sel == WB_SEL_DM) ? main_q.dm_data : main_q.alu_data;

  assign fwd_valid   = out_w_enable;
  assign fwd_rd_addr = main_q.rd_addr;
  assign fwd_data    = out_wb_data;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
module tb_mem_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_dm_data, in_alu_data;
  logic [4:0]  in_rd_addr;
  logic        in_w_enable, in_wb_sel;
  logic        out_valid, out_ready;
  logic [31:0] out_dm_data, out_alu_data, out_wb_data, fwd_data;
  logic [4:0]  out_rd_addr, fwd_rd_addr;
  logic        out_w_enable, out_wb_sel, fwd_valid;

  mem_wb_pipe_reg #(.DATA_W(32), .ADDR_W(5), .SKID(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dm_data   (in_dm_data),
    .in_alu_data  (in_alu_data),
    .in_rd_addr   (in_rd_addr),
    .in_w_enable  (in_w_enable),
    .in_wb_sel    (in_wb_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_dm_data  (out_dm_data),
    .out_alu_data (out_alu_data),
    .out_rd_addr  (out_rd_addr),
    .out_w_enable (out_w_enable),
    .out_wb_sel   (out_wb_sel),
    .out_wb_data  (out_wb_data),
    .fwd_valid    (fwd_valid),
    .fwd_rd_addr  (fwd_rd_addr),
    .fwd_data     (fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   last_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every handoff must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got wb=%h rd=%0d want none", out_wb_data, out_rd_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("mon_wb_data", out_wb_data, mon_e.wb);
        chk("mon_rd_addr", {27'd0, out_rd_addr}, {27'd0, mon_e.rd});
        chk("mon_w_enable", {31'd0, out_w_enable}, {31'd0, mon_e.we});
        chk("mon_fwd_valid", {31'd0, fwd_valid}, {31'd0, mon_e.we});
        chk("mon_fwd_data", fwd_data, mon_e.wb);
        chk("mon_fwd_rd", {27'd0, fwd_rd_addr}, {27'd0, mon_e.rd});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat; push its expectation once the DUT shows in_ready.
  task automatic send(input logic [31:0] dm, input logic [31:0] alu, input logic [4:0] rd,
                      input logic we, input logic sel, input logic [31:0] exp_wb,
                      input logic exp_we);
    exp_t e;
    int   cyc;
    in_dm_data  = dm;
    in_alu_data = alu;
    in_rd_addr  = rd;
    in_w_enable = we;
    in_wb_sel   = sel;
    in_valid    = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    last_wait = cyc;
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=%b want 1", in_ready);
    end else begin
      e.wb = exp_wb;
      e.rd = rd;
      e.we = exp_we;
      sb.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_dm_data = '0; in_alu_data = '0; in_rd_addr = '0; in_w_enable = 1'b0; in_wb_sel = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_wb_data", out_wb_data, 0);
    chk("rst_out_rd", {27'd0, out_rd_addr}, 0);
    chk("rst_out_we_sel", {30'd0, out_w_enable, out_wb_sel}, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    step();

    // 1: single beat selecting dm data
    send(32'hDEADBEEF, 32'h10, 5'd5, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    chk("t1_out_valid", {31'd0, out_valid}, 1);
    chk("t1_wb_data", out_wb_data, 32'hDEADBEEF);
    chk("t1_fwd_valid", {31'd0, fwd_valid}, 1);
    chk("t1_fwd_rd", {27'd0, fwd_rd_addr}, 5);
    drain();

    // 2: back-to-back stream, no stalls expected
    for (int i = 1; i <= 8; i++) begin
      send(32'hA5A50000 + i, i, i[4:0], 1'b1, 1'b0, i, 1'b1);
      chk("t2_no_stall", last_wait, 0);
    end
    drain();

    // 3: backpressure fills main then skid; C must wait
    out_ready = 1'b0;
    send(32'h0, 32'hAAAA, 5'd1, 1'b1, 1'b0, 32'hAAAA, 1'b1);
    send(32'h0, 32'hBBBB, 5'd2, 1'b1, 1'b0, 32'hBBBB, 1'b1);
    in_alu_data = 32'hCCCC; in_rd_addr = 5'd3; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t3_in_ready_low", {31'd0, in_ready}, 0);
      chk("t3_hold_A", out_wb_data, 32'hAAAA);
      step();
    end
    out_ready = 1'b1;
    send(32'h0, 32'hCCCC, 5'd3, 1'b1, 1'b0, 32'hCCCC, 1'b1);
    drain();

    // 4: x0 squash
    send(32'h0, 32'h1234, 5'd0, 1'b1, 1'b0, 32'h1234, 1'b0);
    @(negedge clk);
    chk("t4_out_valid", {31'd0, out_valid}, 1);
    chk("t4_out_we", {31'd0, out_w_enable}, 0);
    chk("t4_fwd_valid", {31'd0, fwd_valid}, 0);
    drain();

    // 5: flush with skid full and a pending input
    out_ready = 1'b0;
    send(32'h0, 32'h5001, 5'd7, 1'b1, 1'b0, 32'h5001, 1'b1);
    send(32'h0, 32'h5002, 5'd8, 1'b1, 1'b0, 32'h5002, 1'b1);
    in_alu_data = 32'h5003; in_rd_addr = 5'd9; in_valid = 1'b1;
    flush = 1'b1;
    sb.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", {31'd0, out_valid}, 0);
    chk("t5_in_ready", {31'd0, in_ready}, 1);
    chk("t5_fwd_valid", {31'd0, fwd_valid}, 0);
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    @(negedge clk);
    chk("t5_stays_empty", {31'd0, out_valid}, 0);
    step();

    // 6: reset during stall with skid full, then resume
    out_ready = 1'b0;
    send(32'h0, 32'h6001, 5'd10, 1'b1, 1'b0, 32'h6001, 1'b1);
    send(32'h0, 32'h6002, 5'd11, 1'b1, 1'b0, 32'h6002, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    step();
    @(negedge clk);
    chk("t6_out_valid", {31'd0, out_valid}, 0);
    chk("t6_wb_data", out_wb_data, 0);
    chk("t6_dm_alu", out_dm_data | out_alu_data, 0);
    chk("t6_rd_we_sel", {25'd0, out_rd_addr, out_w_enable, out_wb_sel}, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", {31'd0, in_ready}, 1);
    step();
    for (int i = 0; i < 3; i++)
      send(32'h7000 + i, 32'h0, 5'd20 + i[4:0], 1'b1, 1'b1, 32'h7000 + i, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
